// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default parameters for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned MAX_DPRIO_DEF = 3;
    localparam int unsigned MEM_AW_DEF    = 6;

    // Which requester owns the response slot of the following cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter bundled into one interface.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW = MEM_AW_DEF
);

    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side.
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts consecutive data grants while a fetch waits; flags when fetch must win.
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DPRIO = MAX_DPRIO_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic d_gnt_i,
    output logic starve_o
);

    localparam int unsigned CW = (MAX_DPRIO < 1) ? 1 : $clog2(MAX_DPRIO + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DPRIO);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear when fetch is idle or served, otherwise count data grants up to the cap.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (d_gnt_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter with one-cycle response routing.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DPRIO = MAX_DPRIO_DEF,
    parameter int unsigned MEM_AW    = MEM_AW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    owner_e owner_q;
    owner_e owner_d;
    logic   store_q;
    logic   store_d;
    logic   starve;

    logic              if_gnt;
    logic              d_gnt;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    arb_starve_ctr #(
        .MAX_DPRIO (MAX_DPRIO)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .if_req_i (bus.if_req),
        .if_gnt_i (if_gnt),
        .d_gnt_i  (d_gnt),
        .starve_o (starve)
    );

    // Grant selection, memory strobe and response routing from the owner register.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        owner_d   = OWN_NONE;
        store_d   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (!reset) begin
            if (bus.d_req && !(bus.if_req && starve)) begin
                d_gnt   = 1'b1;
                owner_d = OWN_D;
                store_d = bus.d_we;
            end else if (bus.if_req) begin
                if_gnt  = 1'b1;
                owner_d = OWN_IF;
            end
        end

        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr[MEM_AW+1:2];
            mem_wdata = bus.d_we ? bus.d_wdata : '0;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = bus.if_addr[MEM_AW+1:2];
        end

        // Reset gating also drops a response owed from the cycle before reset.
        if_rvalid = !reset && (owner_q == OWN_IF);
        d_rvalid  = !reset && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? bus.mem_rdata : '0;
        d_rdata   = (d_rvalid && !store_q) ? bus.mem_rdata : '0;
    end

    // Owner and store-flag registers for next-cycle response routing.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            store_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            store_q <= store_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_rvalid = if_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.d_rdata   = d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DPRIO, default 3: max consecutive data grants while a fetch request waits.
REQ-002 Parameter MEM_AW, default 6: memory word-address width (64 words).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held with if_addr until if_gnt.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch response valid.
REQ-009 if_rdata  out  32  fetch response word.
REQ-010 d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_gnt  out  1  data request accepted this cycle.
REQ-015 d_rvalid  out  1  data response valid (loads and stores).
REQ-016 d_rdata  out  32  load data; 0 for store responses.
REQ-017 mem_en  out  1  memory access strobe.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  MEM_AW  memory word index.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-022 At most one grant per cycle; if_gnt and d_gnt are never both 1.
REQ-023 Grant is combinational from req and state; in the grant cycle mem_en=1, mem_addr=granted addr[MEM_AW+1:2], mem_we=d_we for data grant, 0 for fetch.
REQ-024 addr[1:0] and addr[31:MEM_AW+2] are ignored; out-of-range addresses wrap modulo 2^MEM_AW words.
REQ-025 Priority: data wins, unless if_req=1 and starve count == MAX_DPRIO, in which case fetch wins.
REQ-026 Starve count: +1 on each data grant while if_req=1; cleared on fetch grant or any cycle with if_req=0; saturates at MAX_DPRIO.
REQ-027 Response latency is exactly 1 cycle: the requester granted in cycle N sees rvalid=1 in cycle N+1, and rdata=mem_rdata (load/fetch) or 0 (store).
REQ-028 Owner register (NONE/IF/D) records the grant of cycle N and routes the cycle N+1 response; the rvalid of the non-owner is 0.
REQ-029 Back-to-back operation: a new grant in cycle N+1 is permitted concurrently with the response to cycle N, sustaining one access per cycle.
REQ-030 No requests: mem_en=0, both gnt=0, owner becomes NONE next cycle.
REQ-031 Outside a grant cycle, mem_we=0 and mem_addr/mem_wdata are don't-care but held at 0.
REQ-032 Request withdrawn before grant: no access; no state change other than REQ-026.

Reset
REQ-033 While reset=1: all gnt, rvalid, mem_en, mem_we = 0; rdata outputs = 0; no grant issued regardless of requests.
REQ-034 Reset clears starve count to 0 and owner to NONE; a response pending from the cycle before reset is dropped.
REQ-035 The first grant may occur in the first cycle with reset=0.

Structure
REQ-036 Shared package holds the owner enum (NONE, IF, D), MAX_DPRIO default, and MEM_AW default.
REQ-037 One sub-module, arb_starve_ctr, implements the saturating counter of REQ-026 and outputs the starve flag.

Verification
REQ-038 Fetch only: if_req=1 and addr 0x0,0x4,0x8 on successive cycles -> if_gnt each cycle, mem_addr 0,1,2, and if_rvalid with memory words 0,1,2 one cycle later.
REQ-039 Store then load: d_we=1, d_addr=0x14, d_wdata=0xDEADBEEF, then a load from 0x14 -> d_rvalid with rdata 0, then d_rvalid with rdata 0xDEADBEEF.
REQ-040 Contention: if_req and d_req held high for 8 cycles with MAX_DPRIO=3 -> grant pattern D,D,D,IF repeated twice.
REQ-041 Wrap: d_addr=0x100 with MEM_AW=6 -> mem_addr=0; d_addr=0x7 -> mem_addr=1.
REQ-042 Reset mid-operation: a fetch is granted in cycle N and reset=1 in N+1 -> if_rvalid=0 in N+1, starve count 0, and the first grant occurs after reset drops.
REQ-043 Idle: no requests for 5 cycles -> mem_en=0 and all gnt/rvalid=0 throughout.
